cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Two-entry, fully-associative, write-through cache controller.
- Accepts single read/write requests from one requester over a valid/ready handshake and looks them up in its internal 2-way tag/data store.
- Serves read hits locally. Sequences backing-memory traffic for read misses (fetch then allocate) and for all writes (write-through, no write-allocate).
- Sits between the core-side requester and the memory port; keeps saturating hit/miss statistics counters.

Parameters:
- ADDR_W, 8, request/memory address width
- DATA_W, 32, data width
- STAT_W, 16, width of each hit/miss statistics counter

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request; high only in IDLE
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_hit  out  1  request hit in cache; valid with resp_valid
- resp_rdata  out  DATA_W  read data; 0 for writes
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  memory write
- mem_req_addr  out  ADDR_W  memory address
- mem_req_wdata  out  DATA_W  memory write data
- mem_resp_valid  in  1  read data return; sampled only in WAIT_RD
- mem_resp_rdata  in  DATA_W  read data
- hit_count  out  STAT_W  saturating count of hits
- miss_count  out  STAT_W  saturating count of misses

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; both valid bits=0; lru=0.
  - All outputs 0 except req_ready=1; counters=0.
  - Tag/data contents are don't-care.
  - Reset mid-transaction aborts the transaction silently; no resp_valid is produced.
  - A late mem_resp_valid arriving after reset is ignored.
- Storage:
  - Ways 0/1, each with valid, tag[ADDR_W], data[DATA_W].
  - hit_w = valid_w & (tag_w == addr). At most one way matches (invariant).
- States: IDLE, LOOKUP, MEM_RD, WAIT_RD, MEM_WR.
- IDLE:
  - req_ready=1.
  - On req_valid at edge E0: latch write/addr/wdata, go to LOOKUP.
- LOOKUP (evaluated at edge E1):
  - Read hit: resp_valid=1, resp_hit=1, resp_rdata=hit way data; lru := other way; hit_count++; go to IDLE.
    - Read-hit latency: resp_valid high in the cycle after E1.
    - req_ready is high in the same cycle as resp_valid.
  - Read miss: miss_count++; mem_req_valid=1, mem_req_write=0, mem_req_addr=addr; go to MEM_RD.
  - Write: on a hit, overwrite that way's data and set lru := other way. No allocation on a miss. Increment hit_count or miss_count. Latch the hit flag; mem_req_valid=1, mem_req_write=1, addr/wdata driven; go to MEM_WR.
- MEM_RD:
  - mem_req_* held stable while mem_req_valid=1.
  - On mem_req_ready: drop mem_req_valid, go to WAIT_RD.
- WAIT_RD:
  - On mem_resp_valid, choose a victim: way 0 if invalid, else way 1 if invalid, else the lru way.
  - Fill victim (valid=1, tag=addr, data=mem_resp_rdata); lru := other way.
  - resp_valid=1, resp_hit=0, resp_rdata=mem_resp_rdata; go to IDLE.
  - mem_resp_valid is never expected in the same cycle as the mem_req handshake.
- MEM_WR:
  - Hold request until mem_req_ready.
  - On the handshake edge: mem_req_valid=0, resp_valid=1, resp_hit=latched flag, resp_rdata=0; go to IDLE.
- Output timing and timeouts:
  - resp_valid is exactly one cycle; resp_hit and resp_rdata return to 0 otherwise.
  - No timeout; the controller waits indefinitely on memory.
- Counters: saturate at 2^STAT_W-1 and never wrap.
- Throughput: at most one request per 2 cycles; req_valid while req_ready=0 is ignored (requester holds it).

Test Plan:
- Read miss into empty cache: read 0x10, memory returns 0xDEADBEEF after 3 cycles -> resp_hit=0, resp_rdata=0xDEADBEEF, way 0 filled, miss_count=1.
- Read hit: repeat read 0x10 -> resp_valid the cycle after LOOKUP, resp_hit=1, resp_rdata=0xDEADBEEF, no mem_req_valid, hit_count=1.
- LRU replacement: read misses 0x10, 0x20, read hit 0x10, read miss 0x30 -> 0x30 replaces 0x20; subsequent read 0x10 hits, read 0x20 misses.
- Write-through: write 0x10=0x12345678 with mem_req_ready held low 4 cycles -> mem_req_* stable throughout, resp_hit=1 after handshake, later read 0x10 hits with 0x12345678. Write to 0x55 (miss) -> resp_hit=0 and no allocation.
- Reset mid-operation: assert reset_n=0 in WAIT_RD, release, then drive stale mem_resp_valid -> no resp_valid; counters 0; read 0x10 misses.
- Saturation: STAT_W=2, six read hits -> hit_count stays 3.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// Core and memory handshake bundle for the two-way write-through cache.
// slave is the controller's view; master is the requester/memory side.
interface cache_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_hit;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_hit, resp_rdata,
    output mem_req_valid, mem_req_write,
    output mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_hit, resp_rdata,
    input  mem_req_valid, mem_req_write,
    input  mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/cache_ctrl.sv
// Two-entry fully-associative write-through cache controller
// with saturating hit/miss statistics.
module cache_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int STAT_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  cache_ctrl_if.slave       bus,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MEM_RD, WAIT_RD, MEM_WR
  } state_t;

  state_t state, state_nx;

  logic              wr_q;
  logic              hit_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [1:0]        vld;
  logic              lru;
  logic [ADDR_W-1:0] tag  [2];
  logic [DATA_W-1:0] data [2];

  logic              rsp_vld_q;
  logic              rsp_hit_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic [1:0] hit;
  logic       hit_any;
  logic       hit_way;
  logic       victim;
  logic       fill;

  assign hit[0]  = vld[0] && (tag[0] == addr_q);
  assign hit[1]  = vld[1] && (tag[1] == addr_q);
  assign hit_any = |hit;
  assign hit_way = hit[1];

  // Free ways are used before evicting the LRU way.
  assign victim = !vld[0] ? 1'b0 :
                  !vld[1] ? 1'b1 : lru;

  assign fill = (state == WAIT_RD) &&
                bus.mem_resp_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx          = state;
    bus.req_ready     = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_write = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_wdata = '0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nx = LOOKUP;
      end
      LOOKUP: begin
        if (wr_q)         state_nx = MEM_WR;
        else if (hit_any) state_nx = IDLE;
        else              state_nx = MEM_RD;
      end
      MEM_RD: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = addr_q;
        if (bus.mem_req_ready) state_nx = WAIT_RD;
      end
      WAIT_RD: begin
        if (bus.mem_resp_valid) state_nx = IDLE;
      end
      MEM_WR: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = 1'b1;
        bus.mem_req_addr  = addr_q;
        bus.mem_req_wdata = wdata_q;
        if (bus.mem_req_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q       <= 1'b0;
      hit_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      vld        <= '0;
      lru        <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_hit_q  <= 1'b0;
      rsp_data_q <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      rsp_vld_q  <= 1'b0;
      rsp_hit_q  <= 1'b0;
      rsp_data_q <= '0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
          end
        end
        LOOKUP: begin
          hit_q <= hit_any;
          if (hit_any) begin
            lru <= ~hit_way;
            if (hit_count != '1)
              hit_count <= hit_count + STAT_W'(1);
          end else if (miss_count != '1) begin
            miss_count <= miss_count + STAT_W'(1);
          end
          if (!wr_q && hit_any) begin
            rsp_vld_q  <= 1'b1;
            rsp_hit_q  <= 1'b1;
            rsp_data_q <= data[hit_way];
          end
        end
        WAIT_RD: begin
          if (fill) begin
            vld[victim] <= 1'b1;
            lru         <= ~victim;
            rsp_vld_q   <= 1'b1;
            rsp_data_q  <= bus.mem_resp_rdata;
          end
        end
        MEM_WR: begin
          if (bus.mem_req_ready) begin
            rsp_vld_q <= 1'b1;
            rsp_hit_q <= hit_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clock) begin
    if (state == LOOKUP && wr_q && hit_any)
      data[hit_way] <= wdata_q;
    if (fill) begin
      tag[victim]  <= addr_q;
      data[victim] <= bus.mem_resp_rdata;
    end
  end

  assign bus.resp_valid = rsp_vld_q;
  assign bus.resp_hit   = rsp_hit_q;
  assign bus.resp_rdata = rsp_data_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized and directed bench for cache_ctrl against a
// timestamp-LRU cache model and a flat backing-memory model.
module tb_cache_ctrl;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int SW  = 2;
  localparam int MAX = (1 << SW) - 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic [SW-1:0] hit_count;
  logic [SW-1:0] miss_count;

  always #5 clock = ~clock;

  cache_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cache_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .STAT_W(SW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [256];
  bit            m_vld  [2];
  logic [AW-1:0] m_tag  [2];
  logic [DW-1:0] m_data [2];
  int            m_used [2];
  int            tick;
  int            m_hits;
  int            m_miss;

  typedef struct {
    bit            got;
    bit            hit;
    logic [DW-1:0] rdata;
    int            lat;
    bit            rdy;
    int            mreq;
    bit            mw;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    bit            stable;
    bit            pulse_ok;
  } res_t;

  function automatic int sat(input int v);
    return (v > MAX) ? MAX : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_vld[i]  = 1'b0;
      m_used[i] = 0;
    end
    tick   = 0;
    m_hits = 0;
    m_miss = 0;
  endtask

  // Abstract cache: search both ways; refill a free way, else the
  // one with the oldest use timestamp.
  task automatic model_access(
    input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
    output bit h, output logic [DW-1:0] rd
  );
    int way = -1;
    int v;
    tick++;
    for (int i = 0; i < 2; i++)
      if (m_vld[i] && m_tag[i] == a) way = i;
    h = (way >= 0);
    if (h) m_hits++;
    else   m_miss++;
    rd = '0;
    if (w) begin
      mem[a] = d;
      if (h) begin
        m_data[way] = d;
        m_used[way] = tick;
      end
    end else if (h) begin
      rd          = m_data[way];
      m_used[way] = tick;
    end else begin
      if (!m_vld[0])      v = 0;
      else if (!m_vld[1]) v = 1;
      else                v = (m_used[0] < m_used[1]) ? 0 : 1;
      m_vld[v]  = 1'b1;
      m_tag[v]  = a;
      m_data[v] = mem[a];
      m_used[v] = tick;
      rd        = mem[a];
    end
  endtask

  task automatic do_reset();
    reset_n                = 1'b0;
    bus.req_valid          = 1'b0;
    bus.req_write          = 1'b0;
    bus.req_addr           = '0;
    bus.req_wdata          = '0;
    bus.mem_req_ready      = 1'b0;
    bus.mem_resp_valid     = 1'b0;
    bus.mem_resp_rdata     = '0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
  endtask

  // Drives one request and plays the memory side; samples at edge+1.
  task automatic txn(
    input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
    input int rdy_dly, input int rsp_dly, output res_t r
  );
    bit hs      = 1'b0;
    bit hs_pend = 1'b0;
    int pc      = 0;
    r = '{default: 0};
    r.stable = 1'b1;
    for (int i = 0; i < 50 && !bus.req_ready; i++) begin
      @(posedge clock);
      #1;
    end
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = AW'($urandom);
    bus.req_wdata = $urandom;
    for (int c = 0; c < 300; c++) begin
      if (hs_pend) begin
        hs      = 1'b1;
        hs_pend = 1'b0;
      end
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = $urandom;
      if (bus.resp_valid) begin
        r.got   = 1'b1;
        r.hit   = bus.resp_hit;
        r.rdata = bus.resp_rdata;
        r.lat   = c;
        r.rdy   = bus.req_ready;
        break;
      end
      if (bus.mem_req_valid) begin
        if (r.mreq == 0) begin
          r.mw = bus.mem_req_write;
          r.ma = bus.mem_req_addr;
          r.md = bus.mem_req_wdata;
        end else if (r.mw !== bus.mem_req_write ||
                     r.ma !== bus.mem_req_addr ||
                     r.md !== bus.mem_req_wdata) begin
          r.stable = 1'b0;
        end
        r.mreq++;
        if (r.mreq > rdy_dly) begin
          bus.mem_req_ready = 1'b1;
          hs_pend           = 1'b1;
        end
      end
      if (hs && !w) begin
        if (pc == rsp_dly) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_rdata = mem[a];
        end
        pc++;
      end
      @(posedge clock);
      #1;
    end
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    @(posedge clock);
    #1;
    r.pulse_ok = !bus.resp_valid && !bus.resp_hit &&
                 bus.resp_rdata == '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 ||
        bus.resp_hit !== 1'b0 || bus.resp_rdata !== '0) begin
      errors++;
      $display("FAIL reset_resp: rdy=%b vld=%b hit=%b data=%h exp 1/0/0/0",
               bus.req_ready, bus.resp_valid, bus.resp_hit,
               bus.resp_rdata);
    end
    checks++;
    if (bus.mem_req_valid !== 1'b0 || bus.mem_req_write !== 1'b0 ||
        bus.mem_req_addr !== '0 || bus.mem_req_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mem: vld=%b wr=%b addr=%h data=%h exp zeros",
               bus.mem_req_valid, bus.mem_req_write,
               bus.mem_req_addr, bus.mem_req_wdata);
    end
    checks++;
    if (hit_count !== '0 || miss_count !== '0) begin
      errors++;
      $display("FAIL reset_cnt: hit=%0d miss=%0d exp 0/0",
               hit_count, miss_count);
    end
  endtask

  task automatic test_read_miss_hit();
    res_t r;
    do_reset();
    mem[8'h10] = 32'hDEADBEEF;
    txn(1'b0, 8'h10, '0, 0, 3, r);
    checks++;
    if (!r.got || r.hit !== 1'b0 || r.rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_miss: got=%b hit=%b data=%h exp 1/0/deadbeef",
               r.got, r.hit, r.rdata);
    end
    checks++;
    if (r.mreq != 1 || r.mw !== 1'b0 || r.ma !== 8'h10) begin
      errors++;
      $display("FAIL read_miss_mem: n=%0d wr=%b addr=%h exp 1/0/10",
               r.mreq, r.mw, r.ma);
    end
    checks++;
    if (miss_count !== 2'd1 || hit_count !== 2'd0) begin
      errors++;
      $display("FAIL read_miss_cnt: miss=%0d hit=%0d exp 1/0",
               miss_count, hit_count);
    end
    txn(1'b0, 8'h10, '0, 0, 0, r);
    checks++;
    if (!r.got || r.hit !== 1'b1 || r.rdata !== 32'hDEADBEEF ||
        r.lat != 1 || r.rdy !== 1'b1) begin
      errors++;
      $display("FAIL read_hit: got=%b hit=%b data=%h lat=%0d rdy=%b exp 1/1/deadbeef/1/1",
               r.got, r.hit, r.rdata, r.lat, r.rdy);
    end
    checks++;
    if (r.mreq != 0 || hit_count !== 2'd1 || !r.pulse_ok) begin
      errors++;
      $display("FAIL read_hit_side: mreq=%0d hit_cnt=%0d pulse=%b exp 0/1/1",
               r.mreq, hit_count, r.pulse_ok);
    end
  endtask

  task automatic test_lru();
    res_t r;
    logic [AW-1:0] seq [6] = '{8'h10, 8'h20, 8'h10, 8'h30, 8'h10, 8'h20};
    bit            exp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit            mh;
    logic [DW-1:0] md;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      txn(1'b0, seq[i], '0, 1, 1, r);
      model_access(1'b0, seq[i], '0, mh, md);
      checks++;
      if (!r.got || r.hit !== exp[i] || r.rdata !== md) begin
        errors++;
        $display("FAIL lru_%0d: addr=%h hit=%b data=%h exp %b/%h",
                 i, seq[i], r.hit, r.rdata, exp[i], md);
      end
    end
  endtask

  task automatic test_write_through();
    res_t r;
    bit            mh;
    logic [DW-1:0] md;
    do_reset();
    txn(1'b0, 8'h10, '0, 0, 0, r);
    model_access(1'b0, 8'h10, '0, mh, md);
    txn(1'b1, 8'h10, 32'h12345678, 4, 0, r);
    model_access(1'b1, 8'h10, 32'h12345678, mh, md);
    checks++;
    if (!r.stable || r.mreq != 5 || r.mw !== 1'b1 ||
        r.ma !== 8'h10 || r.md !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_mem: stable=%b n=%0d wr=%b addr=%h data=%h exp 1/5/1/10/12345678",
               r.stable, r.mreq, r.mw, r.ma, r.md);
    end
    checks++;
    if (!r.got || r.hit !== 1'b1 || r.rdata !== '0 || !r.pulse_ok) begin
      errors++;
      $display("FAIL wr_hit_resp: got=%b hit=%b data=%h pulse=%b exp 1/1/0/1",
               r.got, r.hit, r.rdata, r.pulse_ok);
    end
    txn(1'b0, 8'h10, '0, 0, 0, r);
    checks++;
    if (r.hit !== 1'b1 || r.rdata !== 32'h12345678 || r.mreq != 0) begin
      errors++;
      $display("FAIL wr_readback: hit=%b data=%h mreq=%0d exp 1/12345678/0",
               r.hit, r.rdata, r.mreq);
    end
    model_access(1'b0, 8'h10, '0, mh, md);
    txn(1'b1, 8'h55, 32'hCAFEF00D, 2, 0, r);
    model_access(1'b1, 8'h55, 32'hCAFEF00D, mh, md);
    checks++;
    if (!r.got || r.hit !== 1'b0 || r.ma !== 8'h55 || r.mw !== 1'b1) begin
      errors++;
      $display("FAIL wr_miss: got=%b hit=%b addr=%h wr=%b exp 1/0/55/1",
               r.got, r.hit, r.ma, r.mw);
    end
    txn(1'b0, 8'h55, '0, 0, 1, r);
    checks++;
    if (r.hit !== 1'b0 || r.rdata !== 32'hCAFEF00D || r.mreq == 0) begin
      errors++;
      $display("FAIL wr_no_alloc: hit=%b data=%h mreq=%0d exp 0/cafef00d/>0",
               r.hit, r.rdata, r.mreq);
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    bit seen = 1'b0;
    do_reset();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h10;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clock);
    #1;
    bus.mem_req_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.mem_req_ready = 1'b0;
    reset_n           = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      bus.mem_resp_valid = 1'b0;
      if (bus.resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen || hit_count !== '0 || miss_count !== '0 ||
        bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: resp=%b hit=%0d miss=%0d rdy=%b exp 0/0/0/1",
               seen, hit_count, miss_count, bus.req_ready);
    end
    txn(1'b0, 8'h10, '0, 0, 0, r);
    checks++;
    if (!r.got || r.hit !== 1'b0 || r.rdata !== mem[8'h10]) begin
      errors++;
      $display("FAIL rst_mid_read: got=%b hit=%b data=%h exp 1/0/%h",
               r.got, r.hit, r.rdata, mem[8'h10]);
    end
  endtask

  task automatic test_saturation();
    res_t r;
    int   bad = 0;
    do_reset();
    txn(1'b0, 8'h10, '0, 0, 0, r);
    for (int i = 0; i < 6; i++) begin
      txn(1'b0, 8'h10, '0, 0, 0, r);
      if (r.hit !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || hit_count !== 2'd3 || miss_count !== 2'd1) begin
      errors++;
      $display("FAIL saturate: misses_seen=%0d hit=%0d miss=%0d exp 0/3/1",
               bad, hit_count, miss_count);
    end
  endtask

  task automatic test_random();
    res_t r;
    bit            w;
    bit            eh;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] ed;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      w = ($urandom_range(0, 3) == 0);
      a = 8'h40 + AW'($urandom_range(0, 3));
      d = $urandom;
      txn(w, a, d, $urandom_range(0, 3), $urandom_range(0, 3), r);
      model_access(w, a, d, eh, ed);
      checks++;
      if (!r.got || r.hit !== eh || r.rdata !== ed || !r.pulse_ok) begin
        errors++;
        $display("FAIL rnd_resp[%0d]: w=%b a=%h got=%b hit=%b data=%h exp hit=%b data=%h",
                 n, w, a, r.got, r.hit, r.rdata, eh, ed);
      end
      checks++;
      if (!w && eh) begin
        if (r.mreq != 0 || r.lat != 1) begin
          errors++;
          $display("FAIL rnd_hitpath[%0d]: mreq=%0d lat=%0d exp 0/1",
                   n, r.mreq, r.lat);
        end
      end else if (r.mreq == 0 || !r.stable || r.ma !== a ||
                   r.mw !== w || (w && r.md !== d)) begin
        errors++;
        $display("FAIL rnd_mem[%0d]: n=%0d stable=%b addr=%h wr=%b data=%h exp %h/%b/%h",
                 n, r.mreq, r.stable, r.ma, r.mw, r.md, a, w, d);
      end
      checks++;
      if (hit_count !== SW'(sat(m_hits)) ||
          miss_count !== SW'(sat(m_miss))) begin
        errors++;
        $display("FAIL rnd_cnt[%0d]: hit=%0d miss=%0d exp %0d/%0d",
                 n, hit_count, miss_count, sat(m_hits), sat(m_miss));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    model_reset();
    test_reset();
    test_read_miss_hit();
    test_lru();
    test_write_through();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
